// File: rtl/div_pkg.sv
// div_pkg: shared widths, error bit indices and tag/result types for the divider back-end.
package div_pkg;
  localparam int W = 32;
  localparam int NSTAGES = 32;
  localparam int ERR_TUF = 0;
  localparam int ERR_TOF = 1;
  localparam int ERR_CNT = 2;
  localparam int ERR_ROF = 3;
  typedef struct packed {
    logic qneg;
    logic rneg;
    logic dz;
  } tag_t;
  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         sat;
  } res_t;
endpackage

// File: rtl/div_post_fifo.sv
// div_post_fifo: synchronous first-word-fall-through FIFO; a push while full is accepted only with a same-cycle pop.
module div_post_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_wr, w_rd;
  assign w_rd = i_pop & ~o_empty;
  assign w_wr = i_push & (~o_full | w_rd);
  assign o_full = r_cnt == FULL_CNT;
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_dout = r_mem[r_rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_wr);
      r_rp <= r_rp + AW'(w_rd);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= i_din;
endmodule

// File: rtl/divide_post.sv
// divide_post: divider back-end; re-attaches sign/zero tags, corrects sign and saturates, buffers results with upstream credits.
// DIVIDE_POST_ROUND_EN selects round-to-nearest instead of truncation.
module divide_post
  import div_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tag_push,
  input  logic         tag_qneg,
  input  logic         tag_rneg,
  input  logic         tag_dz,
  output logic         credit_ok,
  input  logic         v_in,
  input  logic [W-1:0] Q_in,
  input  logic [W-1:0] R_in,
  input  logic [W-1:0] B_in,
  input  logic [4:0]   count_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_q,
  output logic [W-1:0] out_r,
  output logic         out_dz,
  output logic         out_sat,
  output logic [3:0]   err,
  input  logic         err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] CNT_EXP = 5'(NSTAGES % 32);
  localparam logic [AW+1:0] OCC_LIM = (AW+2)'(DEPTH);
  localparam logic [W-1:0] Q_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] Q_MIN = {1'b1, {(W-1){1'b0}}};
  tag_t w_tag_in, w_tag_head, r_tag;
  res_t w_s2, r_s2, w_rhead, w_out;
  logic w_tfull, w_tempty, w_tpop, w_tpush_ok;
  logic w_rfull, w_rempty, w_rpop, w_dec;
  logic [AW:0] w_tcnt_unused, w_rcnt_unused;
  logic r_s1_v, r_s2_v, r_credit;
  logic [W-1:0] r_q, r_r, w_rm;
  logic [W:0] w_qm;
  logic w_sat;
  logic [AW+1:0] r_occ, w_occ_nxt;
  logic [3:0] r_err, w_err_set;
`ifdef DIVIDE_POST_ROUND_EN
  logic [W-1:0] r_b;
  logic w_up;
`else
  logic w_b_unused;
  assign w_b_unused = ^B_in;
`endif
  assign w_tag_in = '{qneg: tag_qneg, rneg: tag_rneg, dz: tag_dz};
  assign w_tpop = v_in & ~w_tempty;
  assign w_tpush_ok = tag_push & (~w_tfull | w_tpop);
  assign w_rpop = ~w_rempty & out_ready;
  div_post_fifo #(.WIDTH($bits(tag_t)), .DEPTH(DEPTH)) u_tag_fifo (
    .clk(clk), .rst(rst), .i_push(tag_push), .i_pop(v_in), .i_din(w_tag_in),
    .o_dout(w_tag_head), .o_full(w_tfull), .o_empty(w_tempty), .o_count(w_tcnt_unused)
  );
  div_post_fifo #(.WIDTH($bits(res_t)), .DEPTH(DEPTH)) u_res_fifo (
    .clk(clk), .rst(rst), .i_push(r_s2_v), .i_pop(w_rpop), .i_din(r_s2),
    .o_dout(w_rhead), .o_full(w_rfull), .o_empty(w_rempty), .o_count(w_rcnt_unused)
  );
  // A handshake with no tracked operation (tagless v_in) must not wrap the counter
  assign w_dec = w_rpop & (r_occ != '0);
  assign w_occ_nxt = r_occ + (AW+2)'(w_tpush_ok) - (AW+2)'(w_dec);
  always_comb begin
    w_err_set = '0;
    w_err_set[ERR_TUF] = v_in & w_tempty;
    w_err_set[ERR_TOF] = tag_push & w_tfull & ~w_tpop;
    w_err_set[ERR_CNT] = v_in & (count_in != CNT_EXP);
    w_err_set[ERR_ROF] = r_s2_v & w_rfull & ~w_rpop;
  end
  always_comb begin
`ifdef DIVIDE_POST_ROUND_EN
    w_up = ~r_tag.dz & ({r_r, 1'b0} >= {1'b0, r_b});
    w_qm = {1'b0, r_q} + (W+1)'(w_up);
    w_rm = w_up ? r_r - r_b : r_r;
`else
    w_qm = {1'b0, r_q};
    w_rm = r_r;
`endif
    w_sat = r_tag.dz | (~r_tag.qneg & (w_qm > {1'b0, Q_MAX}));
    w_s2.dz = r_tag.dz;
    w_s2.sat = w_sat;
    w_s2.q = r_tag.dz ? (r_tag.qneg ? Q_MIN : Q_MAX) : w_sat ? Q_MAX : r_tag.qneg ? -w_qm[W-1:0] : w_qm[W-1:0];
    w_s2.r = r_tag.dz ? '0 : r_tag.rneg ? -w_rm : w_rm;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_occ <= '0;
      r_credit <= 1'b1;
      r_err <= '0;
    end else begin
      r_s1_v <= v_in;
      r_s2_v <= r_s1_v;
      r_occ <= w_occ_nxt;
      r_credit <= w_occ_nxt < OCC_LIM;
      r_err <= (err_clr ? '0 : r_err) | w_err_set;
    end
    if (v_in) begin
      r_q <= Q_in;
      r_r <= R_in;
      r_tag <= w_tempty ? '0 : w_tag_head;
`ifdef DIVIDE_POST_ROUND_EN
      r_b <= B_in;
`endif
    end
    if (r_s1_v) r_s2 <= w_s2;
  end
  assign w_out = w_rempty ? '0 : w_rhead;
  assign out_valid = ~w_rempty;
  assign out_q = w_out.q;
  assign out_r = w_out.r;
  assign out_dz = w_out.dz;
  assign out_sat = w_out.sat;
  assign credit_ok = r_credit;
  assign err = r_err;
endmodule

// File: tb/tb_divide_post.sv
// tb_divide_post: directed vectors with a result scoreboard popped by an output monitor.
module tb_divide_post;
  logic clk = 1'b0, rst = 1'b1;
  logic tag_push = 0, tag_qneg = 0, tag_rneg = 0, tag_dz = 0, credit_ok;
  logic v_in = 0, out_valid, out_ready = 0, out_dz, out_sat, err_clr = 0;
  logic [31:0] Q_in = 0, R_in = 0, B_in = 0, out_q, out_r;
  logic [4:0] count_in = 0;
  logic [3:0] err;
  int total = 0, bad = 0;
  logic [65:0] sb[$];

  always #5 clk = ~clk;

  divide_post dut (
    .clk(clk), .rst(rst), .tag_push(tag_push), .tag_qneg(tag_qneg), .tag_rneg(tag_rneg),
    .tag_dz(tag_dz), .credit_ok(credit_ok), .v_in(v_in), .Q_in(Q_in), .R_in(R_in),
    .B_in(B_in), .count_in(count_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_dz(out_dz), .out_sat(out_sat), .err(err),
    .err_clr(err_clr)
  );

  function automatic logic [65:0] e(input logic [31:0] q, input logic [31:0] r, input logic dz, input logic sat);
    return {q, r, dz, sat};
  endfunction

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_tag(input logic qn, input logic rn, input logic d);
    tag_push = 1; tag_qneg = qn; tag_rneg = rn; tag_dz = d;
    tick();
    tag_push = 0;
  endtask

  task automatic fire(input logic [31:0] q, input logic [31:0] r, input logic [31:0] b, input logic [4:0] c, input logic [65:0] ex);
    v_in = 1; Q_in = q; R_in = r; B_in = b; count_in = c;
    sb.push_back(ex);
    tick();
    v_in = 0;
  endtask

  task automatic wait_empty;
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    chk("drain", 66'(sb.size()), 66'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected: got %0h with nothing expected", {out_q, out_r, out_dz, out_sat});
      end else chk("result", {out_q, out_r, out_dz, out_sat}, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    chk("rst_valid", 66'(out_valid), 66'd0);
    chk("rst_credit", 66'(credit_ok), 66'd1);
    chk("rst_err", 66'(err), 66'd0);
    chk("rst_out", {out_q, out_r, out_dz, out_sat}, 66'd0);
    rst = 0;
    out_ready = 1;
    push_tag(0, 0, 0);
    fire(14, 2, 7, 0, e(14, 2, 0, 0));
    chk("lat_e0", 66'(out_valid), 66'd0);
    tick();
    chk("lat_e1", 66'(out_valid), 66'd0);
    tick();
    chk("lat_e2", 66'(out_valid), 66'd1);
    push_tag(1, 1, 0);
    push_tag(0, 0, 1);
    push_tag(1, 1, 0);
    push_tag(0, 1, 0);
    push_tag(1, 0, 1);
    push_tag(0, 0, 0);
    fire(14, 2, 7, 0, e(32'hFFFFFFF2, 32'hFFFFFFFE, 0, 0));
    fire(32'hFFFFFFFF, 7, 0, 0, e(32'h7FFFFFFF, 0, 1, 1));
    fire(32'h80000000, 0, 1, 0, e(32'h80000000, 0, 0, 0));
    fire(32'h80000000, 0, 1, 0, e(32'h7FFFFFFF, 0, 0, 1));
    fire(32'hFFFFFFFF, 3, 0, 0, e(32'h80000000, 0, 1, 1));
`ifdef DIVIDE_POST_ROUND_EN
    fire(12, 4, 8, 0, e(13, 32'hFFFFFFFC, 0, 0));
`else
    fire(12, 4, 8, 0, e(12, 4, 0, 0));
`endif
    wait_empty();
    chk("err_clean", 66'(err), 66'd0);
    chk("credit_idle", 66'(credit_ok), 66'd1);
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      push_tag(0, 0, 0);
      if (i == 6) chk("credit_7", 66'(credit_ok), 66'd1);
    end
    chk("credit_8", 66'(credit_ok), 66'd0);
    push_tag(1, 1, 1);
    chk("tag_ovf", 66'(err), 66'b0010);
    for (int i = 0; i < 8; i++) fire(32'(i + 1), 0, 1, 0, e(32'(i + 1), 0, 0, 0));
    repeat (3) tick();
    chk("hold_valid", 66'(out_valid), 66'd1);
    chk("hold_q", 66'(out_q), 66'd1);
    chk("credit_full", 66'(credit_ok), 66'd0);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("credit_back", 66'(credit_ok), 66'd1);
    out_ready = 1;
    wait_empty();
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("err_clr1", 66'(err), 66'd0);
    fire(5, 1, 7, 0, e(5, 1, 0, 0));
    chk("tag_unf", 66'(err), 66'b0001);
    push_tag(1, 1, 0);
    fire(14, 2, 7, 5, e(32'hFFFFFFF2, 32'hFFFFFFFE, 0, 0));
    chk("cnt_err", 66'(err), 66'b0101);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("err_clr2", 66'(err), 66'd0);
    err_clr = 1;
    fire(9, 0, 7, 0, e(9, 0, 0, 0));
    err_clr = 0;
    chk("clr_vs_set", 66'(err), 66'b0001);
    wait_empty();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/divide_post.md
Name: divide_post

Overview:
- Back-end of the pipelined restoring divider.
- Consumes the raw magnitude quotient/remainder emitted by the last divide stage and re-attaches per-operation sign/zero tags pushed by the front-end at issue time.
- Applies sign correction and saturation, then buffers results behind a valid/ready output.
- Issues credits upstream, so the backpressure-free stage chain can never overflow the result buffer.

Parameters:
- W, 32: datapath width (quotient, remainder, divisor).
- NSTAGES, 32: number of divide stages upstream; the expected count_in is NSTAGES mod 32.
- DEPTH, 8: tag FIFO depth, result FIFO depth and credit limit (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- tag_push  in  1  front-end issued one operation this cycle
- tag_qneg  in  1  quotient negative (sign(a) xor sign(b))
- tag_rneg  in  1  remainder negative (sign(a))
- tag_dz  in  1  divisor was zero
- credit_ok  out  1  front-end may issue (outstanding < DEPTH)
- v_in  in  1  last-stage result valid
- Q_in  in  W  magnitude quotient from last stage
- R_in  in  W  magnitude remainder from last stage
- B_in  in  W  magnitude divisor from last stage
- count_in  in  5  stage counter from last stage
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_q  out  W  signed quotient
- out_r  out  W  signed remainder
- out_dz  out  1  divide-by-zero result
- out_sat  out  1  quotient saturated
- err  out  4  sticky: [0] tag underflow, [1] tag overflow, [2] count mismatch, [3] result overflow
- err_clr  in  1  clears err

Behaviour:
- Reset: both FIFOs empty; occupancy counter 0; credit_ok=1; out_valid=0; out_q=0; out_r=0; out_dz=0; out_sat=0; err=0; pipeline valids cleared. Reset mid-operation discards all in-flight tags and results.
- Occupancy counter:
  - +1 on accepted tag_push; -1 on output handshake (out_valid & out_ready); both in the same cycle leave it unchanged.
  - credit_ok = occ < DEPTH, registered from the next-state value.
- Tag FIFO (sync, DEPTH):
  - Push on tag_push; pop on v_in.
  - Push when full: tag dropped, err[1] set.
  - Same-cycle push and pop when full: allowed.
- Stage 1 (registered, on v_in):
  - Pop tag; capture Q_in, R_in, B_in and the tags.
  - If the tag FIFO is empty on v_in, including a same-cycle push: use tags {0,0,0}, set err[0]. No bypass.
  - count_in != NSTAGES[4:0]: set err[2]; the result is still produced.
- Stage 2 (registered), computed from stage-1 data:
  - dz: q = qneg ? 0x80000000 : 0x7FFFFFFF; r = 0; out_sat = 1.
  - else if !qneg and Q > 0x7FFFFFFF: q = 0x7FFFFFFF; out_sat = 1.
  - else q = qneg ? -Q : Q (two's complement, W bits; magnitude 2^31 negated stays 0x80000000, no saturation).
  - r = rneg ? -R : R.
  - Result is pushed into the result FIFO.
- Result FIFO (sync, DEPTH, first-word-fall-through):
  - Outputs are driven from the FIFO head; out_valid = !empty.
  - Push when full: result dropped, err[3] set. Unreachable when the front-end honours credit_ok.
  - Simultaneous push and pop when full: allowed.
- Latency: v_in at edge t -> out_valid high after edge t+2 when the result FIFO is empty.
- Throughput: one result per cycle.
- Output hold: out_* hold stable while out_valid & !out_ready.
- err bits are set-only until err_clr; err_clr and a new error in the same cycle leave the bit set.

Optional Feature:
- Macro: DIVIDE_POST_ROUND_EN.
- Defined: stage 2 rounds to nearest. If !dz and 2*R >= B (computed at W+1 bits), magnitude Q+1 is used before sign and saturation, and r = R - B with the sign applied (remainder consistent with the rounded quotient).
- Undefined: truncation toward zero; B_in is unused.

Decomposition:
- Package div_pkg:
  - W, NSTAGES
  - err bit index constants
  - packed tag type {qneg, rneg, dz}
  - packed result type {q, r, dz, sat}
- Sub-module div_post_fifo: generic sync first-word-fall-through FIFO (width, depth params; full/empty/count outputs). Instantiated twice, for the tag FIFO and the result FIFO.

Test Plan:
- 100/7: tags {0,0,0}, Q=14, R=2, count=0 -> out_q=14, out_r=2, out_valid two cycles after v_in.
- -100/7: tags {1,1,0}, Q=14, R=2 -> out_q=-14 (0xFFFFFFF2), out_r=-2; 7/0 with dz=1, qneg=0 -> out_q=0x7FFFFFFF, out_dz=1, out_sat=1.
- -2^31/1: qneg=1, Q=0x80000000 -> out_q=0x80000000, sat=0. -2^31/-1: qneg=0, Q=0x80000000 -> out_q=0x7FFFFFFF, sat=1.
- out_ready=0 with 8 pushes -> credit_ok=0 after the 8th; drain one -> credit_ok=1 next cycle; results come out in order.
- v_in with tag FIFO empty -> err[0]=1, result treated as positive; count_in=5 -> err[2]=1; err_clr -> err=0.
- 100/8, Q=12, R=4, B=8 -> out_q=13, out_r=-4 with DIVIDE_POST_ROUND_EN defined; out_q=12, out_r=4 without it.
